train_phase_scheduler: RTL
==========================

# train_phase_scheduler

Top-level training sequencer for the CNN training datapath. Steps the forward-pass conv engine, forward-pass FC engine, backward-pass FC engine, backward-pass conv engine and weight-gradient (WG) engine through one training iteration, repeated `num_iter` times. Drives the shared MAC-array operand muxes (`select0`/`select1`), issues one-cycle start pulses and consumes the engines' completion pulses. Guards every phase with a watchdog timeout.

## Interface
- `ITER_W`, 8: width of the iteration count.
- `TIMEOUT`, 1024: maximum cycles per phase before error; must be ≥ 2.
- `clk` in 1: clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: return to IDLE from any state; highest priority after `rst`.
- `stride` in 1: conv stride select; captured on accepted `start`.
- `num_iter` in ITER_W: iterations per run; captured on accepted `start`; 0 is treated as 1.
- `fp_c_complete`, `fp_fc_complete`, `bp_fc_complete`, `bp_c_complete`, `wg_complete` in 1 each: one-cycle engine done pulses.
- `fp_c_start`, `fp_fc_start`, `bp_fc_start`, `bp_c_start`, `wg_start` out 1 each: one-cycle engine launch pulses.
- `stride_cfg` out 1: captured stride, held for the whole run.
- `select0` out 1: 1 while a BP phase owns the MAC array (BP_FC, BP_C).
- `select1` out 1: 1 while WG owns the MAC array.
- `fc_mode` out 1: 1 in FP_FC and BP_FC; 0 otherwise.
- `phase` out 3: current state code.
- `iter_cnt` out ITER_W: index of the current iteration, starting at 0.
- `busy` out 1: 1 in every state except IDLE, DONE and ERR.
- `done` out 1: one-cycle pulse at run completion.
- `error` out 1: sticky timeout flag.

## Operation
- States and `phase` codes: IDLE=0, FP_C=1, FP_FC=2, BP_FC=3, BP_C=4, WG=5, DONE=6, ERR=7.
- IDLE, `start`=1: capture `stride`, `num_iter`; clear `iter_cnt`; go to FP_C. While not in IDLE, `start` is ignored.
- Start pulses are Moore outputs: the engine's `*_start` is 1 only on the first cycle of its state.
- Phase chain is FP_C → FP_FC → BP_FC → BP_C → WG. Each transition fires when the matching `*_complete` is high.
- A completion pulse is acted on only in its own state. Completions from other engines are ignored and are not queued.
- WG complete with `iter_cnt`+1 ≥ max(`num_iter`,1): go to DONE. Otherwise increment `iter_cnt` and go to FP_C.
- DONE lasts one cycle with `done`=1, then goes to IDLE. `iter_cnt` holds its final value until the next accepted `start`.
- Watchdog: a per-phase cycle counter clears on every state entry. If it reaches TIMEOUT-1 in a phase state without that phase's completion, go to ERR.
- ERR: `error`=1. The block stays in ERR until `abort` or `rst`. `abort` clears `error` and goes to IDLE.
- `abort` in any non-IDLE state: next state is IDLE. No `done` pulse, no start pulse, `iter_cnt` held. `abort` wins over a same-cycle completion.
- Mux decode: FP_C/FP_FC give `select0`=0, `select1`=0. BP_FC/BP_C give `select0`=1, `select1`=0. WG gives `select0`=0, `select1`=1. All other states give 0/0. `select0` and `select1` are never 1 together.

## Timing
- Reset values: state IDLE; all outputs 0, including `stride_cfg`, `iter_cnt`, `phase`, `error` and the internal watchdog counter.
- `start` in cycle t: `phase`=1 and `fp_c_start`=1 in cycle t+1.
- `*_complete` in cycle t: next state and its start pulse in cycle t+1.
- A completion in the same cycle as that phase's start pulse is accepted, so the minimum phase length is 1 cycle.
- With immediate completions, one iteration takes 5 cycles. A run of N iterations reaches DONE 5N+1 cycles after `start`.
- All outputs are registered or decoded only from the state register; no input-to-output combinational path.
- Timeout: with no completion, ERR is entered at cycle TIMEOUT after phase entry. A completion on the cycle the counter hits TIMEOUT-1 takes priority over timeout.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `start`=1 → all outputs 0, `phase`=0; after release, `start` → `fp_c_start` the next cycle.
- Single iteration, `num_iter`=1, `stride`=1, each engine completes 3 cycles after its start → start pulses in FP_C, FP_FC, BP_FC, BP_C, WG order. `select0`/`select1`/`fc_mode` follow the decode in each phase. `stride_cfg`=1 throughout. `done` pulses once, then `phase`=0.
- `num_iter`=3 with immediate completions → `iter_cnt` goes 0, 1, 2. `done` arrives 16 cycles after `start`. `num_iter`=0 behaves as 1 (`done` 6 cycles after `start`).
- Stray completions: assert `bp_c_complete` and `wg_complete` during FP_C → no state change. Then `fp_c_complete` → FP_FC.
- Timeout, TIMEOUT=16: no `fp_fc_complete` → ERR 16 cycles after FP_FC entry. `error` stays 1 and `start` is ignored. `abort` → IDLE with `error`=0.
- Abort mid-run in BP_FC, same cycle as `bp_fc_complete` → IDLE the next cycle. No `bp_c_start`, no `done`, `select0` drops to 0.

Source files
------------

// File: rtl/train_phase_scheduler.sv
// Training-iteration sequencer: walks the FP conv, FP FC, BP FC, BP conv and WG engines
// through num_iter iterations, steering the shared MAC-array muxes, with a per-phase watchdog.
module train_phase_scheduler #(
   parameter int ITER_W  = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              stride,
   input  logic [ITER_W-1:0] num_iter,
   input  logic              fp_c_complete,
   input  logic              fp_fc_complete,
   input  logic              bp_fc_complete,
   input  logic              bp_c_complete,
   input  logic              wg_complete,
   output logic              fp_c_start,
   output logic              fp_fc_start,
   output logic              bp_fc_start,
   output logic              bp_c_start,
   output logic              wg_start,
   output logic              stride_cfg,
   output logic              select0,
   output logic              select1,
   output logic              fc_mode,
   output logic [2:0]        phase,
   output logic [ITER_W-1:0] iter_cnt,
   output logic              busy,
   output logic              done,
   output logic              error
);

   // state | meaning
   // IDLE  | waiting for start
   // FP_C  | forward conv engine running
   // FP_FC | forward FC engine running
   // BP_FC | backward FC engine running (MAC array on select0)
   // BP_C  | backward conv engine running (MAC array on select0)
   // WG    | weight-gradient engine running (MAC array on select1)
   // DONE  | one-cycle run-complete pulse
   // ERR   | watchdog expired, held until abort
   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FP_C  = 3'd1,
      S_FP_FC = 3'd2,
      S_BP_FC = 3'd3,
      S_BP_C  = 3'd4,
      S_WG    = 3'd5,
      S_DONE  = 3'd6,
      S_ERR   = 3'd7
   } state_t;

   localparam int CNT_W = $clog2(TIMEOUT);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  wdog_q, wdog_d;
   logic [ITER_W-1:0] iter_q, iter_d;
   logic [ITER_W-1:0] num_q, num_d;
   logic              stride_q, stride_d;
   logic [4:0]        start_q, start_d;
   logic              in_phase;
   logic              phase_done;
   logic              wdog_tc;
   logic              last_iter;
   logic [ITER_W:0]   iter_next_w;

   always_comb begin
      state_d     = state_q;
      iter_d      = iter_q;
      num_d       = num_q;
      stride_d    = stride_q;
      start_d     = '0;
      wdog_d      = '0;
      in_phase    = (state_q == S_FP_C) || (state_q == S_FP_FC) || (state_q == S_BP_FC)
                    || (state_q == S_BP_C) || (state_q == S_WG);
      phase_done  = 1'b0;
      case (state_q)
         S_FP_C:  phase_done = fp_c_complete;
         S_FP_FC: phase_done = fp_fc_complete;
         S_BP_FC: phase_done = bp_fc_complete;
         S_BP_C:  phase_done = bp_c_complete;
         S_WG:    phase_done = wg_complete;
         default: phase_done = 1'b0;
      endcase
      wdog_tc     = (wdog_q == CNT_W'(TIMEOUT - 1));
      iter_next_w = {1'b0, iter_q} + {{ITER_W{1'b0}}, 1'b1};
      // num_q already holds max(num_iter,1), so this compare never sees zero
      last_iter   = (iter_next_w >= {1'b0, num_q});

      if (abort) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  stride_d = stride;
                  num_d    = (num_iter == '0) ? ITER_W'(1) : num_iter;
                  iter_d   = '0;
                  state_d  = S_FP_C;
               end
            end
            S_FP_C:  if (phase_done) state_d = S_FP_FC;
            S_FP_FC: if (phase_done) state_d = S_BP_FC;
            S_BP_FC: if (phase_done) state_d = S_BP_C;
            S_BP_C:  if (phase_done) state_d = S_WG;
            S_WG: begin
               if (phase_done) begin
                  if (last_iter) begin
                     state_d = S_DONE;
                  end else begin
                     iter_d  = iter_q + 1'b1;
                     state_d = S_FP_C;
                  end
               end
            end
            S_DONE:  state_d = S_IDLE;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_IDLE;
         endcase
         if (in_phase && !phase_done && wdog_tc) state_d = S_ERR;
      end

      if (state_d != state_q) begin
         case (state_d)
            S_FP_C:  start_d[0] = 1'b1;
            S_FP_FC: start_d[1] = 1'b1;
            S_BP_FC: start_d[2] = 1'b1;
            S_BP_C:  start_d[3] = 1'b1;
            S_WG:    start_d[4] = 1'b1;
            default: start_d    = '0;
         endcase
      end else if (in_phase) begin
         wdog_d = wdog_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wdog_q   <= '0;
         iter_q   <= '0;
         num_q    <= '0;
         stride_q <= 1'b0;
         start_q  <= '0;
      end else begin
         state_q  <= state_d;
         wdog_q   <= wdog_d;
         iter_q   <= iter_d;
         num_q    <= num_d;
         stride_q <= stride_d;
         start_q  <= start_d;
      end
   end

   assign fp_c_start  = start_q[0];
   assign fp_fc_start = start_q[1];
   assign bp_fc_start = start_q[2];
   assign bp_c_start  = start_q[3];
   assign wg_start    = start_q[4];
   assign stride_cfg  = stride_q;
   assign select0     = (state_q == S_BP_FC) || (state_q == S_BP_C);
   assign select1     = (state_q == S_WG);
   assign fc_mode     = (state_q == S_FP_FC) || (state_q == S_BP_FC);
   assign phase       = state_q;
   assign iter_cnt    = iter_q;
   assign busy        = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);
   assign done        = (state_q == S_DONE);
   assign error       = (state_q == S_ERR);

endmodule
